// File: rtl/systolic_ctrl.sv
// Sequencer for one systolic-array pass: weight load/write, stream, capture, unload.
// Optional SYS_CTRL_PERF_EN adds perf_cycles, the cycle count of the last completed pass.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef ARRAYHEIGHT
`define ARRAYHEIGHT 4
`endif

module systolic_ctrl #(
    parameter int ARRAY_W = `ARRAYWIDTH,
    parameter int ARRAY_H = `ARRAYHEIGHT,
    parameter int NT_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [NT_W-1:0] num_tiles,
    output logic            busy,
    output logic            done,
    output logic [2:0]      state,
    output logic            wb_load_en,
    output logic            wb_out_en,
    output logic            write_weight_en,
    output logic            ib_load_en,
    output logic            ob_load_en,
    output logic            ob_out_en
`ifdef SYS_CTRL_PERF_EN
    ,
    output logic [15:0]     perf_cycles
`endif
);

    localparam int CW  = NT_W + 1;
    localparam int LAT = ARRAY_H + ARRAY_W - 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        WRITE_W = 3'd2,
        COMPUTE = 3'd3,
        UNLOAD  = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e          st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NT_W-1:0] nt_q, nt_d;
    logic            busy_q, done_q, wbl_q, wbo_q, ib_q, obl_q, obo_q;

    logic [CW-1:0] nt_ext;
    logic [CW-1:0] w_last;
    logic [CW-1:0] comp_last;
    logic [CW-1:0] unl_last;

    assign nt_ext    = {1'b0, nt_q};
    assign w_last    = CW'(ARRAY_H - 1);
    assign comp_last = nt_ext + CW'(LAT - 1);
    assign unl_last  = nt_ext - CW'(1);

    always_comb begin
        st_d  = st_q;
        nt_d  = nt_q;
        cnt_d = cnt_q + CW'(1);
        case (st_q)
            IDLE: begin
                cnt_d = '0;
                if (start && !abort) begin
                    if (num_tiles != '0) begin
                        nt_d = num_tiles;
                        st_d = LOAD_W;
                    end else begin
                        st_d = DONE;
                    end
                end
            end
            LOAD_W: if (cnt_q == w_last) begin
                st_d  = WRITE_W;
                cnt_d = '0;
            end
            WRITE_W: if (cnt_q == w_last) begin
                st_d  = COMPUTE;
                cnt_d = '0;
            end
            COMPUTE: if (cnt_q == comp_last) begin
                st_d  = UNLOAD;
                cnt_d = '0;
            end
            UNLOAD: if (cnt_q == unl_last) begin
                st_d  = DONE;
                cnt_d = '0;
            end
            default: begin
                st_d  = IDLE;
                cnt_d = '0;
            end
        endcase
        // Cancel beats every other transition, including the DONE pulse.
        if (abort && st_q != IDLE) begin
            st_d  = IDLE;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            nt_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            wbl_q  <= 1'b0;
            wbo_q  <= 1'b0;
            ib_q   <= 1'b0;
            obl_q  <= 1'b0;
            obo_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            nt_q   <= nt_d;
            busy_q <= (st_d != IDLE);
            done_q <= (st_d == DONE);
            wbl_q  <= (st_d == LOAD_W);
            wbo_q  <= (st_d == WRITE_W);
            ib_q   <= (st_d == COMPUTE) && (cnt_d < {1'b0, nt_d});
            obl_q  <= (st_d == COMPUTE) && (cnt_d >= CW'(LAT));
            obo_q  <= (st_d == UNLOAD);
        end
    end

    assign state           = st_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign wb_load_en      = wbl_q;
    assign wb_out_en       = wbo_q;
    assign write_weight_en = wbo_q;
    assign ib_load_en      = ib_q;
    assign ob_load_en      = obl_q;
    assign ob_out_en       = obo_q;

`ifdef SYS_CTRL_PERF_EN
    logic [15:0] pc_q, pc_d, perf_q;

    always_comb begin
        if (st_q == IDLE)
            pc_d = 16'd1;
        else if (pc_q == 16'hFFFF)
            pc_d = pc_q;
        else
            pc_d = pc_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            perf_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (st_d == DONE)
                perf_q <= pc_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with ARRAY_W=ARRAY_H=4 (LAT=6).
// Cycle 0 is the cycle in which start is sampled; outputs are checked at negedge.
module tb_systolic_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] num_tiles = 8'd0;
    logic       busy, done, wb_load_en, wb_out_en, write_weight_en;
    logic       ib_load_en, ob_load_en, ob_out_en;
    logic [2:0] state;
`ifdef SYS_CTRL_PERF_EN
    logic [15:0] perf_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int last_perf = 0;

    systolic_ctrl #(.ARRAY_W(4), .ARRAY_H(4), .NT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .num_tiles(num_tiles),
        .busy(busy),
        .done(done),
        .state(state),
        .wb_load_en(wb_load_en),
        .wb_out_en(wb_out_en),
        .write_weight_en(write_weight_en),
        .ib_load_en(ib_load_en),
        .ob_load_en(ob_load_en),
        .ob_out_en(ob_out_en)
`ifdef SYS_CTRL_PERF_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] obs();
        return {state, busy, done, wb_load_en, wb_out_en, write_weight_en,
                ib_load_en, ob_load_en, ob_out_en};
    endfunction

    // Expected {state,busy,done,wbl,wbo,wwe,ib,obl,obo} at cycle c of a pass.
    function automatic logic [10:0] exp_vec(int nt, int c, int ab);
        logic [2:0] st;
        logic wbl, wbo, ib, obl, obo, dn;
        if (ab > 0 && c > ab) return 11'd0;
        if (nt == 0) return (c == 1) ? {3'd5, 1'b1, 1'b1, 6'b0} : 11'd0;
        wbl = (c >= 1 && c <= 4);
        wbo = (c >= 5 && c <= 8);
        ib  = (c >= 9 && c <= 8 + nt);
        obl = (c >= 15 && c <= 14 + nt);
        obo = (c >= 15 + nt && c <= 14 + 2 * nt);
        dn  = (c == 15 + 2 * nt);
        if (wbl)                        st = 3'd1;
        else if (wbo)                   st = 3'd2;
        else if (c >= 9 && c <= 14 + nt) st = 3'd3;
        else if (obo)                   st = 3'd4;
        else if (dn)                    st = 3'd5;
        else                            st = 3'd0;
        return {st, (st != 3'd0), dn, wbl, wbo, wbo, ib, obl, obo};
    endfunction

    task automatic check_perf(input string name, input int expv);
`ifdef SYS_CTRL_PERF_EN
        n_tests++;
        if (perf_cycles !== 16'(expv)) begin
            n_fail++;
            $display("FAIL %s perf_cycles got %0d want %0d", name, perf_cycles, expv);
        end
`else
        if (name.len() < 0 || expv < 0) $display("unused");
`endif
    endtask

    task automatic run_pass(input string name, input int nt, input int ab,
                            input int p1, input int p2, input int ncyc);
        logic [10:0] e;
        @(negedge clk);
        start = 1'b1;
        num_tiles = 8'(nt);
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) num_tiles = 8'(nt + 4);
            e = exp_vec(nt, c, ab);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL %s c%0d outputs got %b want %b", name, c, obs(), e);
            end
            start = (c == p1 || c == p2);
            abort = (c == ab);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs() !== 11'd0) begin
            n_fail++;
            $display("FAIL reset outputs got %b want %b", obs(), 11'd0);
        end
        check_perf("reset", 0);
        rst = 1'b0;
    endtask

    task automatic test_nt3();
        run_pass("nt3", 3, 0, 3, 21, 24);
        last_perf = 21;
        check_perf("nt3", last_perf);
    endtask

    task automatic test_nt10();
        run_pass("nt10", 10, 0, 0, 0, 38);
        last_perf = 35;
        check_perf("nt10", last_perf);
    endtask

    task automatic test_nt0();
        run_pass("nt0", 0, 0, 0, 0, 4);
        last_perf = 1;
        check_perf("nt0", last_perf);
    endtask

    task automatic test_abort();
        run_pass("abort", 3, 10, 0, 0, 24);
        check_perf("abort", last_perf);
    endtask

    task automatic test_idle_abort();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        num_tiles = 8'd3;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            n_tests++;
            if (obs() !== 11'd0) begin
                n_fail++;
                $display("FAIL idle_abort c%0d outputs got %b want %b", c, obs(), 11'd0);
            end
        end
        check_perf("idle_abort", last_perf);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        num_tiles = 8'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        n_tests++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_mid pre state got %0d want %0d", state, 3);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (obs() !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid outputs got %b want %b", obs(), 11'd0);
        end
        last_perf = 0;
        check_perf("reset_mid", last_perf);
        @(negedge clk);
        rst = 1'b0;
        run_pass("post_reset", 3, 0, 0, 0, 24);
        last_perf = 21;
        check_perf("post_reset", last_perf);
    endtask

    initial begin
        test_reset();
        test_nt3();
        test_nt10();
        test_nt0();
        test_abort();
        test_idle_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
